// File: rtl/multicycle_control_fsm.sv
// Main control FSM for the O9 multicycle MIPS-subset processor.
// Moore-decoded datapath strobes with memory wait states, sticky illegal-opcode trap and retire counter.
module multicycle_control_fsm #(
  parameter int unsigned MEM_WAIT = 1,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [5:0]         opCode,
  output logic               PCWriteCond,
  output logic               PCWrite,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUOp,
  output logic [2:0]         ALUSrcB,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic               illegal,
  output logic [3:0]         state,
  output logic [COUNT_W-1:0] instr_count
);

  localparam logic [3:0] S_FETCH    = 4'd0;
  localparam logic [3:0] S_DECODE   = 4'd1;
  localparam logic [3:0] S_MEMADR   = 4'd2;
  localparam logic [3:0] S_MEMREAD  = 4'd3;
  localparam logic [3:0] S_MEMWB    = 4'd4;
  localparam logic [3:0] S_MEMWRITE = 4'd5;
  localparam logic [3:0] S_EXECUTE  = 4'd6;
  localparam logic [3:0] S_ALUWB    = 4'd7;
  localparam logic [3:0] S_BRANCH   = 4'd8;
  localparam logic [3:0] S_JUMP     = 4'd9;
  localparam logic [3:0] S_ADDIEX   = 4'd10;
  localparam logic [3:0] S_ADDIWB   = 4'd11;
  localparam logic [3:0] S_ILLEGAL  = 4'd15;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  localparam logic [3:0] WAIT_LAST = 4'(MEM_WAIT);

  logic [3:0] next_state;
  logic [3:0] wait_cnt;
  logic [3:0] wait_nxt;
  logic       wait_last;
  logic       retire;

  assign wait_last = (wait_cnt == WAIT_LAST);

  // State, wait counter, sticky trap flag and retire counter
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= S_FETCH;
      wait_cnt    <= 4'd0;
      illegal     <= 1'b0;
      instr_count <= '0;
    end else begin
      state    <= next_state;
      wait_cnt <= wait_nxt;
      if (next_state == S_ILLEGAL) illegal <= 1'b1;
      if (retire) instr_count <= instr_count + COUNT_W'(1);
    end
  end

  // Next state; the wait counter idles at zero so FETCH/MEMREAD always enter with a clear count
  always_comb begin
    next_state = state;
    wait_nxt   = 4'd0;
    retire     = 1'b0;
    case (state)
      S_FETCH: begin
        if (wait_last) next_state = S_DECODE;
        else           wait_nxt   = wait_cnt + 4'd1;
      end
      S_DECODE: begin
        case (opCode)
          OP_RTYPE:      next_state = S_EXECUTE;
          OP_LW, OP_SW:  next_state = S_MEMADR;
          OP_BEQ:        next_state = S_BRANCH;
          OP_J:          next_state = S_JUMP;
          OP_ADDI:       next_state = S_ADDIEX;
          default:       next_state = S_ILLEGAL;
        endcase
      end
      S_MEMADR: begin
        if (opCode == OP_LW)      next_state = S_MEMREAD;
        else if (opCode == OP_SW) next_state = S_MEMWRITE;
        else                      next_state = S_ILLEGAL;
      end
      S_MEMREAD: begin
        if (wait_last) next_state = S_MEMWB;
        else           wait_nxt   = wait_cnt + 4'd1;
      end
      S_EXECUTE: next_state = S_ALUWB;
      S_ADDIEX:  next_state = S_ADDIWB;
      S_MEMWB, S_MEMWRITE, S_ALUWB, S_BRANCH, S_JUMP, S_ADDIWB: begin
        next_state = S_FETCH;
        retire     = 1'b1;
      end
      S_ILLEGAL: next_state = S_ILLEGAL;
      default:   next_state = S_ILLEGAL;
    endcase
  end

  // Moore strobes, forced low while reset is asserted; ALU selects are held through dependent states
  always_comb begin
    PCWriteCond = 1'b0;
    PCWrite     = 1'b0;
    IorD        = 1'b0;
    MemRead     = 1'b0;
    MemWrite    = 1'b0;
    MemtoReg    = 1'b0;
    IRWrite     = 1'b0;
    PCSource    = 2'b00;
    ALUOp       = 2'b00;
    ALUSrcB     = 3'b000;
    ALUSrcA     = 1'b0;
    RegWrite    = 1'b0;
    RegDst      = 1'b0;
    if (reset) begin
      case (state)
        S_FETCH: begin
          MemRead = 1'b1;
          ALUSrcB = 3'b001;
          IRWrite = wait_last;
          PCWrite = wait_last;
        end
        S_DECODE: ALUSrcB = 3'b011;
        S_MEMADR: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 3'b010;
        end
        S_MEMREAD: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 3'b010;
          IorD    = 1'b1;
          MemRead = 1'b1;
        end
        S_MEMWB: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 3'b010;
          IorD     = 1'b1;
          MemtoReg = 1'b1;
          RegWrite = 1'b1;
        end
        S_MEMWRITE: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 3'b010;
          IorD     = 1'b1;
          MemWrite = 1'b1;
        end
        S_EXECUTE: begin
          ALUSrcA = 1'b1;
          ALUOp   = 2'b10;
        end
        S_ALUWB: begin
          ALUSrcA  = 1'b1;
          ALUOp    = 2'b10;
          RegDst   = 1'b1;
          RegWrite = 1'b1;
        end
        S_BRANCH: begin
          ALUSrcA     = 1'b1;
          ALUOp       = 2'b01;
          PCWriteCond = 1'b1;
          PCSource    = 2'b01;
        end
        S_JUMP: begin
          PCWrite  = 1'b1;
          PCSource = 2'b10;
        end
        S_ADDIEX: begin
          ALUSrcA = 1'b1;
          ALUSrcB = 3'b010;
        end
        S_ADDIWB: begin
          ALUSrcA  = 1'b1;
          ALUSrcB  = 3'b010;
          RegWrite = 1'b1;
        end
        default: ;
      endcase
    end
  end

endmodule
